// File: rtl/param_regfile.sv
// Parametrised multi-read-port register file with self-clearing sweep after reset.
// Latency: 1 cycle from rd_addr to rd_data; ready rises DEPTH edges after reset release.
// Backpressure: none; writes are ignored and reads return 0 until ready is high.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-high, overrides everything
//   rd_addr  NUM_RD packed read addresses, port k = [k*ADDR_W +: ADDR_W]
//   rd_data  NUM_RD packed registered read data, port k = [k*DATA_W +: DATA_W]
//   wr_en    write enable (honoured only once ready)
//   wr_addr  write address
//   wr_data  write data
//   ready    1 = clear sweep finished, array usable
//
// Optional build macro RF_BYPASS_EN: when defined, a read of the address being
// written on the same edge returns the new data (write-first). When undefined
// the read returns the old contents (read-first).

module param_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     ready
);

    localparam int                DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    // Single array write port shared by the clear sweep and normal writeback.
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                run_wr;

    logic [NUM_RD*DATA_W-1:0] rd_next;

    // Writes to entry 0 are dropped when it is the hardwired zero register.
    assign run_wr = (state == RUN) && wr_en &&
                    !((ZERO_REG != 0) && (wr_addr == '0));

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_cnt;
        mem_wdata = '0;
        if (rst) begin
            mem_we = 1'b0;
        end else if (state == CLEAR) begin
            mem_we = 1'b1;
        end else if (run_wr) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Per-port next read value. The zero-register rule takes priority over the
    // bypass so entry 0 never leaks write data when it is hardwired.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              zero_hit;
        logic              bypass_hit;
        logic [DATA_W-1:0] nxt;

        assign addr     = rd_addr[k*ADDR_W +: ADDR_W];
        assign zero_hit = (ZERO_REG != 0) && (addr == '0);
`ifdef RF_BYPASS_EN
        assign bypass_hit = wr_en && (wr_addr == addr);
`else
        assign bypass_hit = 1'b0;
`endif

        always_comb begin
            nxt = mem[addr];
            if (zero_hit) begin
                nxt = '0;
            end else if (bypass_hit) begin
                nxt = wr_data;
            end
        end

        assign rd_next[k*DATA_W +: DATA_W] = nxt;
    end

    // Control FSM: CLEAR walks clr_cnt over every entry, then RUN serves reads.
    // The last entry is cleared on the same edge that enters RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
            rd_data <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    rd_data <= '0;
                    if (clr_cnt == LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    rd_data <= rd_next;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_regfile.sv
module tb_param_regfile;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 4;
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [2*DW-1:0]  rd_data_nz;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             ready;
    logic             ready_nz;

    always #5 clk = ~clk;

    // Main instance: four read ports, hardwired zero register.
    param_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ready   (ready)
    );

    // Second instance: two read ports, entry 0 is an ordinary register.
    param_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .ZERO_REG(0)) dut_nz (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (rd_addr[2*AW-1:0]),
        .rd_data (rd_data_nz),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ready   (ready_nz)
    );

    typedef struct {
        string         tag;
        int            port;   // 0..3 main instance, 4..5 ordinary-zero instance
        logic [DW-1:0] exp;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mz  [DEPTH];
    logic [DW-1:0] mnz [DEPTH];
    int            checks   = 0;
    int            failures = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected read result given the current (pre-edge) write inputs.
    function automatic logic [DW-1:0] exp_rd(input bit zr, input logic [AW-1:0] a);
        if (zr && a == '0) return '0;
`ifdef RF_BYPASS_EN
        if (wr_en && a == wr_addr) return wr_data;
`endif
        return zr ? mz[a] : mnz[a];
    endfunction

    task automatic run_cycle(input string tag,
                             input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                             input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        logic [AW-1:0] a [4];
        exp_t          e;
        logic [DW-1:0] obs;
        a       = '{a0, a1, a2, a3};
        rd_addr = {a3, a2, a1, a0};
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        for (int k = 0; k < NR; k++) sb.push_back('{tag, k, exp_rd(1'b1, a[k])});
        for (int k = 0; k < 2; k++)  sb.push_back('{tag, 4 + k, exp_rd(1'b0, a[k])});
        @(posedge clk);
        if (we) begin
            if (wa != '0) mz[wa] = wd;
            mnz[wa] = wd;
        end
        #1;
        wr_en = 1'b0;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = (e.port < 4) ? rd_data[e.port*DW +: DW] : rd_data_nz[(e.port-4)*DW +: DW];
            check($sformatf("%s_p%0d", e.tag, e.port), obs, e.exp);
        end
    endtask

    // Hold reset, release, and walk the clear sweep edge by edge.
    task automatic reset_sweep(input int hold, input bit write_at10);
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_addr = '0;
        repeat (hold) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_rd0", rd_data[0 +: DW], 32'd0);
        check("rst_rd3", rd_data[3*DW +: DW], 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            mz[i]  = '0;
            mnz[i] = '0;
        end
        rst = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            if (write_at10 && i == 11) begin
                wr_en   = 1'b1;
                wr_addr = 5'd3;
                wr_data = 32'hAAAA5555;
                rd_addr = {4{5'd3}};
            end
            @(posedge clk);
            #1;
            wr_en = 1'b0;
            check($sformatf("sweep_ready_e%0d", i), {31'b0, ready}, (i == DEPTH) ? 32'd1 : 32'd0);
            check($sformatf("sweep_ready_nz_e%0d", i), {31'b0, ready_nz}, (i == DEPTH) ? 32'd1 : 32'd0);
            check($sformatf("sweep_rd0_e%0d", i), rd_data[0 +: DW], 32'd0);
        end
    endtask

    initial begin
        rst     = 1'b1;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;

        // Reset and full sweep, then every entry reads zero.
        reset_sweep(3, 1'b0);
        for (int a = 0; a < DEPTH; a += 4)
            run_cycle("post_clear", AW'(a), AW'(a+1), AW'(a+2), AW'(a+3), 1'b0, '0, '0);

        // Basic write then read.
        run_cycle("wr1", 0, 0, 0, 0, 1'b1, 5'd1, 32'h0000000F);
        run_cycle("wr2", 0, 0, 0, 0, 1'b1, 5'd2, 32'hDEADBEEF);
        run_cycle("basic", 5'd1, 5'd2, 5'd2, 5'd1, 1'b0, '0, '0);

        // Entry 0: hardwired on main instance, ordinary on the other.
        run_cycle("wr0", 5'd1, 5'd2, 0, 0, 1'b1, 5'd0, 32'h12345678);
        run_cycle("zero", 0, 0, 0, 0, 1'b0, '0, '0);

        // Same-edge read/write on entry 5.
        run_cycle("wr5", 0, 0, 0, 0, 1'b1, 5'd5, 32'h11111111);
        run_cycle("rw5", 5'd5, 5'd5, 5'd5, 5'd5, 1'b1, 5'd5, 32'h22222222);
        run_cycle("rd5", 5'd5, 5'd5, 5'd5, 5'd5, 1'b0, '0, '0);

        // Bypass to a hardwired zero entry must still read 0 on main instance.
        run_cycle("rw0", 0, 0, 0, 0, 1'b1, 5'd0, 32'h55AA55AA);

        // Write attempted during the sweep must be lost.
        reset_sweep(1, 1'b1);
        run_cycle("clr_wr3", 5'd3, 5'd3, 5'd3, 5'd3, 1'b0, '0, '0);

        // Mid-operation reset wipes contents.
        run_cycle("wr7", 0, 0, 0, 0, 1'b1, 5'd7, 32'hCAFEF00D);
        run_cycle("rd7", 5'd7, 5'd7, 5'd7, 5'd7, 1'b0, '0, '0);
        reset_sweep(1, 1'b0);
        run_cycle("rd7_rst", 5'd7, 5'd7, 5'd7, 5'd7, 1'b0, '0, '0);

        // Mixed random traffic checked against the model.
        for (int i = 0; i < 40; i++) begin
            run_cycle("rand", AW'($urandom_range(0, DEPTH-1)), AW'($urandom_range(0, DEPTH-1)),
                      AW'($urandom_range(0, DEPTH-1)), AW'($urandom_range(0, DEPTH-1)),
                      1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)), DW'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_regfile.md
Name: param_regfile

Overview:
Parametrised multi-read-port register file; next-generation replacement for the fixed 32x32, 2-read/1-write processor register file. It has generic width, depth and read-port count, registered synchronous reads, and an optional hardwired-zero entry 0. After reset it runs a self-clearing sweep that zeroes every entry and signals completion through `ready`. It sits between decode (read addresses) and writeback (write port) in the MIPS datapath.

Parameters:
DATA_W, 32, bits per register
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed registered read data; port k = bits [k*DATA_W +: DATA_W]
wr_en  input  1  write enable
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
ready  output  1  1 = clear sweep finished, array usable

Behaviour:
- One clock; reset is synchronous and active-high: `rst` is sampled on rising `clk`, and `rst` high overrides everything.
- FSM states: CLEAR, RUN. Counter `clr_cnt` is ADDR_W bits.
- Reset response: state <= CLEAR, clr_cnt <= 0, ready <= 0, all rd_data <= 0.
- CLEAR, each edge with rst low: mem[clr_cnt] <= 0 and clr_cnt <= clr_cnt+1.
  - When clr_cnt == DEPTH-1: state <= RUN, ready <= 1. Entry DEPTH-1 is cleared on that same edge.
  - ready rises exactly DEPTH edges after the first edge with rst low.
  - wr_en is ignored; rd_data is held at 0.
- RUN, each edge: every read port k updates independently.
  - If ZERO_REG=1 and rd_addr[k]==0: rd_data[k] <= 0.
  - Otherwise rd_data[k] <= mem[rd_addr[k]], or the bypass value (see Optional Feature).
- RUN write: if wr_en and not (ZERO_REG=1 and wr_addr==0), mem[wr_addr] <= wr_data.
- Read latency: 1 cycle; the address presented before edge N appears on rd_data after edge N.
- Multiple read ports may use the same address; all receive identical data.
- rst during CLEAR or RUN: sweep restarts from entry 0. Prior contents are lost. ready drops on that edge.
- rd_data holds its value between edges; no combinational path from rd_addr to rd_data.
- All widths are exact; no truncation or extension inside the block.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: in RUN, if wr_en and rd_addr[k]==wr_addr, rd_data[k] <= wr_data on the same edge (write-first). The ZERO_REG rule still wins: address 0 with ZERO_REG=1 returns 0.
- Undefined: read-first; a same-edge same-address read returns the old mem contents, and the new value is visible from the following edge.

Test Plan:
- Reset sweep (DATA_W=32, ADDR_W=5): hold rst 3 cycles, release -> ready=0 for 32 edges, ready=1 after the 32nd edge; reading all 32 addresses afterwards returns 0x00000000.
- Basic write/read: write 0x0000000F to reg 1 and 0xDEADBEEF to reg 2; next cycle rd_addr0=1, rd_addr1=2 -> one edge later rd_data0=0x0000000F, rd_data1=0xDEADBEEF.
- Zero register: ZERO_REG=1, write 0x12345678 to reg 0, then read addr 0 on both ports -> 0x00000000. With ZERO_REG=0, the same sequence returns 0x12345678.
- Same-edge read/write on reg 5 (old value 0x11111111, write 0x22222222):
  - without RF_BYPASS_EN -> 0x11111111, then 0x22222222 on the next read;
  - with RF_BYPASS_EN -> 0x22222222 immediately.
- Write during CLEAR: wr_en=1, wr_addr=3, wr_data=0xAAAA5555 at sweep cycle 10 -> after ready, reg 3 reads 0x00000000.
- Mid-operation reset: fill reg 7 with 0xCAFEF00D in RUN, pulse rst one cycle -> ready=0 for 32 edges, then reg 7 reads 0x00000000; NUM_RD=4 with all ports on addr 7 -> all four ports return the same value.
